alu_arbiter: RTL and testbench

//  Shares one 64-bit ALU between two requesters (r0, r1) using valid/ready handshakes.

---
 rtl/alu_arbiter.sv | 174 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 64-bit ALU between two valid/ready requesters.
// Round-robin grant, operands registered toward the ALU, result and flags
// registered back onto a single tagged response channel held until accepted.
// Optional build macro: ALU_ARB_OPCHECK_EN (reject opcodes 001/111 with rsp_err).
module alu_arbiter #(
  parameter int WIDTH      = 64,
  parameter int CNTRL_W    = 3,
  parameter int RESET_PRIO = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               r0_valid,
  output logic               r0_ready,
  input  logic [WIDTH-1:0]   r0_A,
  input  logic [WIDTH-1:0]   r0_B,
  input  logic [CNTRL_W-1:0] r0_cntrl,
  input  logic               r1_valid,
  output logic               r1_ready,
  input  logic [WIDTH-1:0]   r1_A,
  input  logic [WIDTH-1:0]   r1_B,
  input  logic [CNTRL_W-1:0] r1_cntrl,
  output logic [WIDTH-1:0]   alu_A,
  output logic [WIDTH-1:0]   alu_B,
  output logic [CNTRL_W-1:0] alu_cntrl,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_negative,
  input  logic               alu_zero,
  input  logic               alu_overflow,
  input  logic               alu_carry_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [3:0]         rsp_flags,
  output logic               rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t               state_q;
  logic                 last_q;     // requester granted most recently
  logic                 id_q;       // requester owning the in-flight op
  logic [WIDTH-1:0]     alu_A_q;
  logic [WIDTH-1:0]     alu_B_q;
  logic [CNTRL_W-1:0]   alu_cntrl_q;
  logic                 rsp_valid_q;
  logic                 rsp_id_q;
  logic [WIDTH-1:0]     rsp_result_q;
  logic [3:0]           rsp_flags_q;

  logic                 gnt0_d;
  logic                 gnt1_d;
  logic                 grant_d;
  logic [WIDTH-1:0]     sel_A_d;
  logic [WIDTH-1:0]     sel_B_d;
  logic [CNTRL_W-1:0]   sel_cntrl_d;

`ifdef ALU_ARB_OPCHECK_EN
  logic                 bad_q;      // in-flight op bypasses the ALU
  logic                 err_q;
  logic                 op_bad_d;

  // Opcodes 001 and 111 have no ALU meaning and are answered with an error.
  function automatic logic is_bad_op(input logic [CNTRL_W-1:0] op);
    return (op == CNTRL_W'(1)) || (op == CNTRL_W'(7));
  endfunction

  assign op_bad_d = is_bad_op(sel_cntrl_d);
  assign rsp_err  = err_q;
`else
  assign rsp_err  = 1'b0;
`endif

  // Round-robin grant, only offered while idle and out of reset.
  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (r0_valid && r1_valid) begin
        if (last_q) gnt0_d = 1'b1;
        else        gnt1_d = 1'b1;
      end else if (r0_valid) begin
        gnt0_d = 1'b1;
      end else if (r1_valid) begin
        gnt1_d = 1'b1;
      end
    end
  end

  assign grant_d     = gnt0_d | gnt1_d;
  assign sel_A_d     = gnt1_d ? r1_A     : r0_A;
  assign sel_B_d     = gnt1_d ? r1_B     : r0_B;
  assign sel_cntrl_d = gnt1_d ? r1_cntrl : r0_cntrl;

  assign r0_ready   = gnt0_d;
  assign r1_ready   = gnt1_d;
  assign alu_A      = alu_A_q;
  assign alu_B      = alu_B_q;
  assign alu_cntrl  = alu_cntrl_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

  // Control FSM IDLE -> EXEC -> HOLD -> IDLE with registered ALU and response paths.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= (RESET_PRIO == 0);
      id_q         <= 1'b0;
      alu_A_q      <= '0;
      alu_B_q      <= '0;
      alu_cntrl_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      bad_q        <= 1'b0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            id_q    <= gnt1_d;
            last_q  <= gnt1_d;
            state_q <= EXEC;
`ifdef ALU_ARB_OPCHECK_EN
            bad_q   <= op_bad_d;
            // A rejected op leaves the ALU inputs on the previous op.
            if (!op_bad_d) begin
              alu_A_q     <= sel_A_d;
              alu_B_q     <= sel_B_d;
              alu_cntrl_q <= sel_cntrl_d;
            end
`else
            alu_A_q     <= sel_A_d;
            alu_B_q     <= sel_B_d;
            alu_cntrl_q <= sel_cntrl_d;
`endif
          end
        end
        EXEC: begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= id_q;
          state_q     <= HOLD;
`ifdef ALU_ARB_OPCHECK_EN
          if (bad_q) begin
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            err_q        <= 1'b1;
          end else begin
            rsp_result_q <= alu_result;
            rsp_flags_q  <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
            err_q        <= 1'b0;
          end
`else
          rsp_result_q <= alu_result;
          rsp_flags_q  <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
`endif
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vectors with hand-computed responses pushed
// into a scoreboard queue; a monitor pops and compares on each response handshake.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [63:0] r0_A, r0_B, r1_A, r1_B;
  logic [2:0]  r0_cntrl, r1_cntrl;
  logic [63:0] alu_A, alu_B, alu_result;
  logic [2:0]  alu_cntrl;
  logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_flags;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(64), .CNTRL_W(3), .RESET_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_A(r0_A), .r0_B(r0_B), .r0_cntrl(r0_cntrl),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_A(r1_A), .r1_B(r1_B), .r1_cntrl(r1_cntrl),
    .alu_A(alu_A), .alu_B(alu_B), .alu_cntrl(alu_cntrl), .alu_result(alu_result),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Reference ALU attached to the registered operand port; undefined opcodes pass A.
  logic [64:0] alu_sum;
  always_comb begin
    alu_sum       = '0;
    alu_result    = alu_A;
    alu_overflow  = 1'b0;
    alu_carry_out = 1'b0;
    case (alu_cntrl)
      3'b000: alu_result = alu_B;
      3'b010: begin
        alu_sum       = {1'b0, alu_A} + {1'b0, alu_B};
        alu_result    = alu_sum[63:0];
        alu_carry_out = alu_sum[64];
        alu_overflow  = (alu_A[63] == alu_B[63]) && (alu_result[63] != alu_A[63]);
      end
      3'b011: begin
        alu_sum       = {1'b0, alu_A} + {1'b0, ~alu_B} + 65'd1;
        alu_result    = alu_sum[63:0];
        alu_carry_out = alu_sum[64];
        alu_overflow  = (alu_A[63] != alu_B[63]) && (alu_result[63] != alu_A[63]);
      end
      3'b100: alu_result = alu_A & alu_B;
      3'b101: alu_result = alu_A | alu_B;
      3'b110: alu_result = alu_A ^ alu_B;
      default: alu_result = alu_A;
    endcase
    alu_negative = alu_result[63];
    alu_zero     = (alu_result == 64'd0);
  end

  typedef struct {
    logic        id;
    logic [63:0] res;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual id=%0d result=0x%0h required=none", rsp_id, rsp_result);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_id",     64'(rsp_id),    64'(mon_e.id));
        chk("rsp_result", rsp_result,     mon_e.res);
        chk("rsp_flags",  64'(rsp_flags), 64'(mon_e.flags));
        chk("rsp_err",    64'(rsp_err),   64'(mon_e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic id, input logic [63:0] res, input logic [3:0] fl,
                              input logic err);
    exp_t e;
    e.id = id; e.res = res; e.flags = fl; e.err = err;
    return e;
  endfunction

  // Present one op, wait for its grant, record the expectation, optionally check latency.
  task automatic issue(input logic id, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] op, input exp_t e, input bit push, input bit lat);
    int n;
    if (id) begin r1_A = a; r1_B = b; r1_cntrl = op; r1_valid = 1'b1; end
    else    begin r0_A = a; r0_B = b; r0_cntrl = op; r0_valid = 1'b1; end
    n = 0;
    @(negedge clk);
    while (!(id ? r1_ready : r0_ready)) begin
      n++;
      if (n > 20) begin
        checks++;
        failures++;
        $display("FAIL grant_timeout actual=no_ready required=ready id=%0d", id);
        r0_valid = 1'b0; r1_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (push) sbq.push_back(e);
    @(posedge clk);
    #1;
    if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
    if (lat) begin
      chk("lat_k1_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_k2_valid", 64'(rsp_valid), 64'd1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    logic g;
    reset = 1'b1; rsp_ready = 1'b1;
    r0_A = 64'd10; r0_B = 64'd1; r0_cntrl = 3'b010; r0_valid = 1'b1;
    r1_A = 64'd20; r1_B = 64'd2; r1_cntrl = 3'b011; r1_valid = 1'b1;

    // Readys must stay low in reset even with both requesters asking.
    repeat (2) begin
      @(negedge clk);
      chk("reset_r0_ready", 64'(r0_ready), 64'd0);
      chk("reset_r1_ready", 64'(r1_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_rsp_valid",  64'(rsp_valid),  64'd0);
    chk("reset_rsp_id",     64'(rsp_id),     64'd0);
    chk("reset_rsp_result", rsp_result,      64'd0);
    chk("reset_rsp_flags",  64'(rsp_flags),  64'd0);
    chk("reset_rsp_err",    64'(rsp_err),    64'd0);
    chk("reset_alu_A",      alu_A,           64'd0);
    chk("reset_alu_cntrl",  64'(alu_cntrl),  64'd0);

    // Both valid continuously: grants alternate 0,1,0,1 starting with r0.
    for (int gi = 0; gi < 4; gi++) begin
      n = 0;
      @(negedge clk);
      while (!(r0_ready || r1_ready) && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("rr_both_ready", 64'(r0_ready && r1_ready), 64'd0);
      chk("rr_grant_r1",   64'(r1_ready), 64'(gi % 2));
      g = r1_ready;
      if (g) sbq.push_back(mk(1'b1, 64'd18, 4'b0001, 1'b0));
      else   sbq.push_back(mk(1'b0, 64'd11, 4'b0000, 1'b0));
      @(posedge clk);
    end
    #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single-requester arithmetic and logic vectors.
    issue(1'b0, 64'd5, 64'd3, 3'b010, mk(1'b0, 64'd8, 4'b0000, 1'b0), 1'b1, 1'b1);
    issue(1'b1, 64'd3, 64'd5, 3'b011, mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0), 1'b1, 1'b1);
    issue(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b010,
          mk(1'b0, 64'd0, 4'b0111, 1'b0), 1'b1, 1'b1);
    issue(1'b1, 64'hF0F0, 64'hFF00, 3'b100, mk(1'b1, 64'hF000, 4'b0000, 1'b0), 1'b1, 1'b1);
    issue(1'b0, 64'h1234, 64'h1234, 3'b110, mk(1'b0, 64'd0, 4'b0100, 1'b0), 1'b1, 1'b1);
    issue(1'b1, 64'd1, 64'h8000_0000_0000_0001, 3'b000,
          mk(1'b1, 64'h8000_0000_0000_0001, 4'b1000, 1'b0), 1'b1, 1'b1);

    // Response held with rsp_ready low: outputs stable and no new grant to r1.
    rsp_ready = 1'b0;
    issue(1'b0, 64'd7, 64'd9, 3'b101, mk(1'b0, 64'd15, 4'b0000, 1'b0), 1'b1, 1'b1);
    r1_A = 64'd100; r1_B = 64'd1; r1_cntrl = 3'b011; r1_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("hold_rsp_valid",  64'(rsp_valid), 64'd1);
      chk("hold_rsp_result", rsp_result,     64'd15);
      chk("hold_r1_ready",   64'(r1_ready),  64'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    issue(1'b1, 64'd100, 64'd1, 3'b011, mk(1'b1, 64'd99, 4'b0001, 1'b0), 1'b1, 1'b1);

    // Opcode 111: rejected with error when op checking is built in, else passed to the ALU.
`ifdef ALU_ARB_OPCHECK_EN
    issue(1'b0, 64'h55, 64'h0F, 3'b111, mk(1'b0, 64'd0, 4'b0000, 1'b1), 1'b1, 1'b1);
    chk("opchk_alu_A_kept",     alu_A,          64'd100);
    chk("opchk_alu_cntrl_kept", 64'(alu_cntrl), 64'(3'b011));
`else
    issue(1'b0, 64'h55, 64'h0F, 3'b111, mk(1'b0, 64'h55, 4'b0000, 1'b0), 1'b1, 1'b1);
    chk("op7_alu_cntrl", 64'(alu_cntrl), 64'(3'b111));
`endif

    // Reset while the op is in EXEC: it is discarded and never answered.
    issue(1'b1, 64'd1, 64'd1, 3'b010, mk(1'b1, 64'd2, 4'b0000, 1'b0), 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_exec_no_rsp", 64'(rsp_valid), 64'd0);
    end
    chk("rst_exec_alu_A", alu_A, 64'd0);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
